// File: rtl/batch_fifo_param.sv
// Multi-lane-write, single-word-read circular FIFO for the DCT transpose path.
// Batches of LANES words enter per beat; words leave one per read, oldest first.
module batch_fifo_param #(
  parameter int DATA_W = 22,
  parameter int LANES  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [LANES*DATA_W-1:0]   din,
  output logic                      wr_ready,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH/LANES-1:0]    batch_full,
  output logic                      ovf,
  output logic                      unf
);

  localparam int NBATCH = DEPTH / LANES;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(NBATCH);
  localparam int RW     = $clog2(DEPTH);
  localparam int LW     = $clog2(LANES);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [RW-1:0]     rd_ptr;
  logic              wr_acc, rd_acc;
  logic [NBATCH-1:0] bf_next;
  logic [CW-1:0]     count_next;
  logic [RW-1:0]     wr_base;
  logic [RW-1:0]     lane_mask;
  logic [PW-1:0]     rd_slot;
  logic              rd_last_lane;

  assign wr_ready = (CW'(DEPTH) - count) >= CW'(LANES);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // Accepts are gated by rst/flush so a request in those cycles never touches memory or pointers.
  assign wr_acc = wr_en && wr_ready && !rst && !flush;
  assign rd_acc = rd_en && !empty && !rst && !flush;

  assign wr_base      = RW'(wr_ptr) << LW;
  assign lane_mask    = RW'(LANES - 1);
  assign rd_last_lane = ((rd_ptr & lane_mask) == lane_mask);
  assign rd_slot      = PW'(rd_ptr >> LW);

  always_comb begin
    count_next = count;
    if (wr_acc) count_next = count_next + CW'(LANES);
    if (rd_acc) count_next = count_next - CW'(1);
  end

  // Clear applied before set so a coincident set on the same slot wins.
  always_comb begin
    bf_next = batch_full;
    if (rd_acc && rd_last_lane) bf_next[rd_slot] = 1'b0;
    if (wr_acc)                 bf_next[wr_ptr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        mem[wr_base + RW'(k)] <= din[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      batch_full <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      batch_full <= '0;
      dout_valid <= 1'b0;
    end else begin
      count      <= count_next;
      batch_full <= bf_next;
      dout_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + RW'(1);
        dout   <= mem[rd_ptr];
      end
      if (wr_en && !wr_ready) ovf <= 1'b1;
      if (rd_en && empty)     unf <= 1'b1;
    end
  end

endmodule
